// File: rtl/priority_decoder_if.sv
// Code-queue handshake bundle between an encoder-side producer and a one-hot consumer.
// The master side feeds codes and acknowledges; the slave side is the decoder.
interface priority_decoder_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [2:0]    in_code;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out;
    logic          out_valid;
    logic          out_ack;
    logic [CW-1:0] count;

    modport master (
        output in_code, in_valid, out_ack,
        input  in_ready, out, out_valid, count
    );

    modport slave (
        input  in_code, in_valid, out_ack,
        output in_ready, out, out_valid, count
    );
endinterface

// File: rtl/priority_decoder.sv
// Queued 3:8 decoder: codes are buffered in a small FIFO and presented one at a
// time as a registered one-hot word, held until the consumer acknowledges it.
//
// state | meaning
// IDLE  | nothing presented; out = 0, out_valid = 0
// DRIVE | head code decoded onto out, waiting for out_ack
module priority_decoder #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    priority_decoder_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE,
        DRIVE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [7:0]    out_q;
    logic [7:0]    out_next;
    logic          push;
    logic          pop;

    // Readiness looks only at the registered count, so a full queue refuses
    // a code even on a cycle where the head is being popped.
    assign bus.in_ready  = (count_q < CW'(DEPTH));
    assign push          = bus.in_valid && bus.in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = (state == DRIVE);
    assign bus.count     = count_q;

    always_comb begin
        state_next = state;
        out_next   = out_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    out_next   = 8'b1 << mem[rd_ptr];
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (bus.out_ack) begin
                    if (count_q != '0) begin
                        pop      = 1'b1;
                        out_next = 8'b1 << mem[rd_ptr];
                    end else begin
                        out_next   = 8'h00;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                out_next   = 8'h00;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            out_q   <= 8'h00;
            count_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state <= state_next;
            out_q <= out_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read behind a nonzero count.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= bus.in_code;
    end
endmodule

// File: tb/tb_priority_decoder.sv
// Directed-vector bench for priority_decoder with DEPTH = 4.
module tb_priority_decoder;
    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    priority_decoder_if #(.DEPTH(4)) bus ();

    priority_decoder #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_code  = 3'd0;
        bus.out_ack  = 1'b0;
        step();
        step();
        rst = 1'b0;
        vectors++;
        if (bus.out !== 8'h00 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: out=%h valid=%b want 00/0", bus.out, bus.out_valid);
        end
        vectors++;
        if (bus.count !== 3'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cnt: count=%0d ready=%b want 0/1", bus.count, bus.in_ready);
        end
    endtask

    task automatic test_single();
        bus.in_code = 3'd5; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL single_latency: valid=%b count=%0d want 0/1", bus.out_valid, bus.count);
        end
        step();
        vectors++;
        if (bus.out !== 8'b00100000 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_out: out=%h valid=%b want 20/1", bus.out, bus.out_valid);
        end
        step();
        vectors++;
        if (bus.out !== 8'b00100000 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_hold: out=%h valid=%b want 20/1", bus.out, bus.out_valid);
        end
        bus.out_ack = 1'b1;
        step();
        bus.out_ack = 1'b0;
        vectors++;
        if (bus.out !== 8'h00 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: out=%h valid=%b want 00/0", bus.out, bus.out_valid);
        end
    endtask

    task automatic test_fill_and_drain();
        logic [7:0] drain_exp [4];
        drain_exp[0] = 8'h08; drain_exp[1] = 8'h10;
        drain_exp[2] = 8'h20; drain_exp[3] = 8'h00;
        bus.out_ack = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd1; step();
        bus.in_code = 3'd2; step();
        vectors++;
        if (bus.out !== 8'h02 || bus.count !== 3'd1) begin
            errors++;
            $display("FAIL fill_first: out=%h count=%0d want 02/1", bus.out, bus.count);
        end
        bus.in_code = 3'd3; step();
        bus.in_code = 3'd4; step();
        bus.in_code = 3'd5; step();
        vectors++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d ready=%b want 4/0", bus.count, bus.in_ready);
        end
        bus.in_code = 3'd6; step();
        vectors++;
        if (bus.count !== 3'd4 || bus.out !== 8'h02) begin
            errors++;
            $display("FAIL full_reject: count=%0d out=%h want 4/02", bus.count, bus.out);
        end
        // Pop while full with a push offered: the push must still be refused.
        bus.out_ack = 1'b1;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out !== 8'h04 || bus.count !== 3'd3) begin
            errors++;
            $display("FAIL full_pop_push: out=%h count=%0d want 04/3", bus.out, bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (bus.out !== drain_exp[i] || bus.out_valid !== (i < 3)) begin
                errors++;
                $display("FAIL drain_%0d: out=%h valid=%b want %h/%b", i, bus.out,
                         bus.out_valid, drain_exp[i], (i < 3));
            end
        end
        bus.out_ack = 1'b0;
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] tail_exp [3];
        tail_exp[0] = 8'h08; tail_exp[1] = 8'h80; tail_exp[2] = 8'h00;
        bus.out_ack = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd1; step();
        bus.in_code = 3'd2; step();
        bus.in_code = 3'd3; step();
        vectors++;
        if (bus.count !== 3'd2 || bus.out !== 8'h02) begin
            errors++;
            $display("FAIL simul_setup: count=%0d out=%h want 2/02", bus.count, bus.out);
        end
        bus.in_code = 3'd7; bus.out_ack = 1'b1;
        step();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.count !== 3'd2 || bus.out !== 8'h04) begin
            errors++;
            $display("FAIL simul_pushpop: count=%0d out=%h want 2/04", bus.count, bus.out);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (bus.out !== tail_exp[i]) begin
                errors++;
                $display("FAIL simul_tail_%0d: out=%h want %h", i, bus.out, tail_exp[i]);
            end
        end
        bus.out_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ack = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_code = 3'd1; step();
        bus.in_code = 3'd2; step();
        bus.in_code = 3'd3; step();
        bus.in_code = 3'd4; step();
        vectors++;
        if (bus.count !== 3'd3 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: count=%0d valid=%b want 3/1", bus.count, bus.out_valid);
        end
        rst = 1'b1; bus.in_code = 3'd5;
        step();
        rst = 1'b0; bus.in_valid = 1'b0;
        vectors++;
        if (bus.out !== 8'h00 || bus.out_valid !== 1'b0 || bus.count !== 3'd0
            || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear: out=%h valid=%b count=%0d ready=%b want 00/0/0/1",
                     bus.out, bus.out_valid, bus.count, bus.in_ready);
        end
        bus.in_code = 3'd0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        vectors++;
        if (bus.out !== 8'h01 || bus.out_valid !== 1'b1 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL midrst_push0: out=%h valid=%b count=%0d want 01/1/0",
                     bus.out, bus.out_valid, bus.count);
        end
        bus.out_ack = 1'b1;
        step();
        bus.out_ack = 1'b0;
    endtask

    task automatic test_wrap();
        logic [2:0] codes [10];
        logic [7:0] exp;
        int         pushed;
        int         seen;
        for (int i = 0; i < 10; i++) codes[i] = 3'(i % 8);
        pushed = 0;
        seen = 0;
        bus.out_ack = 1'b1;
        for (int cyc = 0; cyc < 40 && seen < 10; cyc++) begin
            if (pushed < 10) begin
                bus.in_code  = codes[pushed];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) pushed++;
            step();
            // With ack held high every valid cycle is a fresh presentation.
            if (bus.out_valid) begin
                exp = 8'b1 << codes[seen];
                vectors++;
                if (bus.out !== exp) begin
                    errors++;
                    $display("FAIL wrap_%0d: out=%h want %h", seen, bus.out, exp);
                end
                seen++;
            end
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (seen != 10) begin
            errors++;
            $display("FAIL wrap_count: presented=%0d want 10", seen);
        end
        step();
        bus.out_ack = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_empty: valid=%b count=%0d want 0/0", bus.out_valid, bus.count);
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_single();
        test_fill_and_drain();
        test_simul_push_pop();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
